// File: rtl/pulse_freq_meter.sv
// Purpose  : counts rising edges of an asynchronous divider output over a fixed clk window.
// Latency  : div_in is seen SYNC_STAGES+1 clk later; the result is valid 1 clk after the window ends.
// Backpress: a result is held in HOLD until cnt_ready; edges during HOLD are not counted.
//
// Ports:
//   clk, rst          system clock (rising edge), asynchronous active-high reset
//   en                measurement enable (level, synchronous to clk)
//   div_in            divider output under test (asynchronous)
//   cnt, overflow     edge count and saturation flag of the last completed window
//   cnt_valid/ready   result handshake
//   busy              high while a window is being measured
module pulse_freq_meter #(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_in,
   output logic [CNT_W-1:0] cnt,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             overflow,
   output logic             busy
);

   localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   sync_prev;
   logic                   edge_det;
   logic [GW-1:0]          gate_q;
   logic [CNT_W-1:0]       edge_cnt;
   logic                   ovf_q;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   ovf_inc;
   logic                   accept;

   // Synchronizer chain for the asynchronous divider output, then a 1-clk edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         sync_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], div_in};
         sync_prev <= sync_out;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign edge_det = sync_out & ~sync_prev;
   assign accept   = cnt_valid & cnt_ready;

   // Saturating increment; an edge that cannot be counted marks the window as overflowed.
   always_comb begin
      cnt_inc = edge_cnt;
      ovf_inc = ovf_q;
      if (edge_det) begin
         if (edge_cnt == CNT_MAX) ovf_inc = 1'b1;
         else                     cnt_inc = edge_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = MEASURE;
         end
         MEASURE: begin
            busy = 1'b1;
            if (!en)                    state_nxt = IDLE;
            else if (gate_q == GATE_LAST) state_nxt = HOLD;
         end
         HOLD: begin
            if (accept) state_nxt = en ? MEASURE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters only run in an enabled MEASURE cycle; every other cycle clears them, so an
   // abort discards the partial count and each new window starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_q    <= '0;
         edge_cnt  <= '0;
         ovf_q     <= 1'b0;
         cnt       <= '0;
         overflow  <= 1'b0;
         cnt_valid <= 1'b0;
      end else if (state == MEASURE && en) begin
         if (gate_q == GATE_LAST) begin
            // The edge seen in the final gate cycle is included in the result.
            cnt       <= cnt_inc;
            overflow  <= ovf_inc;
            cnt_valid <= 1'b1;
            gate_q    <= '0;
            edge_cnt  <= '0;
            ovf_q     <= 1'b0;
         end else begin
            gate_q    <= gate_q + 1'b1;
            edge_cnt  <= cnt_inc;
            ovf_q     <= ovf_inc;
         end
      end else begin
         gate_q   <= '0;
         edge_cnt <= '0;
         ovf_q    <= 1'b0;
         if (state == HOLD && accept) cnt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pulse_freq_meter.sv
module tb_pulse_freq_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        div_in = 1'b1;
   logic        cnt_ready = 1'b0;
   logic [15:0] cnt16;
   logic        valid16, ovf16, busy16;
   logic [3:0]  cnt4;
   logic        valid4, ovf4, busy4;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int div_half = 0;   // 0: div_in held, N: div_in toggles every N clk
   int div_cnt  = 0;

   always #5 clk = ~clk;

   pulse_freq_meter #(.GATE_CYCLES(64), .CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in),
      .cnt(cnt16), .cnt_valid(valid16), .cnt_ready(cnt_ready),
      .overflow(ovf16), .busy(busy16)
   );

   pulse_freq_meter #(.GATE_CYCLES(64), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in),
      .cnt(cnt4), .cnt_valid(valid4), .cnt_ready(cnt_ready),
      .overflow(ovf4), .busy(busy4)
   );

   // Divider stimulus, changed on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (div_half > 0) begin
            div_cnt = div_cnt + 1;
            if (div_cnt >= div_half) begin
               div_in  = ~div_in;
               div_cnt = 0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output bit ok, output int cycles);
      ok = 1'b0;
      cycles = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         cycles++;
         if (valid16) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; cnt_ready = 1'b0; div_half = 0; div_in = 1'b1;
      tick(2);
      chk_cnt++; if ({cnt16, valid16, ovf16, busy16} !== 19'd0)
         $display("FAIL reset_dut16: got cnt=%0d v=%b o=%b b=%b, want all 0", cnt16, valid16, ovf16, busy16);
      else pass_cnt++;
      chk_cnt++; if ({cnt4, valid4, ovf4, busy4} !== 7'd0)
         $display("FAIL reset_dut4: got cnt=%0d v=%b o=%b b=%b, want all 0", cnt4, valid4, ovf4, busy4);
      else pass_cnt++;
      rst = 1'b0;
      tick(4);
   endtask

   // T1: div_in steady high, window of 64 clk yields zero edges, valid 65 clk after en.
   task automatic test_single_window;
      en = 1'b1;
      tick(1);
      chk_cnt++; if (busy16 !== 1'b1) $display("FAIL t1_busy: got %b want 1", busy16); else pass_cnt++;
      tick(63);
      chk_cnt++; if (valid16 !== 1'b0) $display("FAIL t1_early_valid: got %b want 0", valid16); else pass_cnt++;
      tick(1);
      chk_cnt++; if (valid16 !== 1'b1) $display("FAIL t1_valid: got %b want 1", valid16); else pass_cnt++;
      chk_cnt++; if (cnt16 !== 16'd0) $display("FAIL t1_cnt: got %0d want 0", cnt16); else pass_cnt++;
      chk_cnt++; if (ovf16 !== 1'b0) $display("FAIL t1_ovf: got %b want 0", ovf16); else pass_cnt++;
      chk_cnt++; if (busy16 !== 1'b0) $display("FAIL t1_hold_busy: got %b want 0", busy16); else pass_cnt++;
   endtask

   // T2: period-8 input, ready held high: each window counts 8, results every 65 clk.
   task automatic test_back_to_back;
      bit ok;
      int cyc;
      div_half = 4;
      cnt_ready = 1'b1;
      wait_valid(ok, cyc);   // first window may straddle the start of toggling
      chk_cnt++; if (!ok) $display("FAIL t2_first_timeout: got no valid, want valid"); else pass_cnt++;
      for (int r = 0; r < 3; r++) begin
         wait_valid(ok, cyc);
         chk_cnt++; if (!ok) $display("FAIL t2_timeout: window %0d got no valid", r); else pass_cnt++;
         chk_cnt++; if (cnt16 !== 16'd8) $display("FAIL t2_cnt: window %0d got %0d want 8", r, cnt16); else pass_cnt++;
         chk_cnt++; if (ovf16 !== 1'b0) $display("FAIL t2_ovf: window %0d got %b want 0", r, ovf16); else pass_cnt++;
         chk_cnt++; if (cyc !== 65) $display("FAIL t2_spacing: window %0d got %0d clk want 65", r, cyc); else pass_cnt++;
      end
      cnt_ready = 1'b0;
   endtask

   // T3: period-2 input gives 32 edges; the 4-bit meter saturates at 15 with overflow.
   task automatic test_saturation;
      bit ok;
      int cyc;
      rst = 1'b1; en = 1'b0; div_half = 1;
      tick(2);
      rst = 1'b0;
      tick(4);
      en = 1'b1;
      wait_valid(ok, cyc);
      chk_cnt++; if (!ok || cyc !== 65) $display("FAIL t3_latency: got ok=%b cyc=%0d want 65", ok, cyc); else pass_cnt++;
      chk_cnt++; if (cnt4 !== 4'd15) $display("FAIL t3_cnt4: got %0d want 15", cnt4); else pass_cnt++;
      chk_cnt++; if (ovf4 !== 1'b1) $display("FAIL t3_ovf4: got %b want 1", ovf4); else pass_cnt++;
      chk_cnt++; if (cnt16 !== 16'd32) $display("FAIL t3_cnt16: got %0d want 32", cnt16); else pass_cnt++;
      chk_cnt++; if (ovf16 !== 1'b0) $display("FAIL t3_ovf16: got %b want 0", ovf16); else pass_cnt++;
   endtask

   // T4: result held for 20 clk of backpressure, then a 1-clk accept restarts measurement.
   task automatic test_backpressure;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk_cnt++; if (valid16 !== 1'b1 || cnt16 !== 16'd32 || busy16 !== 1'b0)
            $display("FAIL t4_hold: clk %0d got v=%b cnt=%0d b=%b want v=1 cnt=32 b=0", i, valid16, cnt16, busy16);
         else pass_cnt++;
      end
      cnt_ready = 1'b1;
      tick(1);
      cnt_ready = 1'b0;
      chk_cnt++; if (valid16 !== 1'b0) $display("FAIL t4_accept_valid: got %b want 0", valid16); else pass_cnt++;
      chk_cnt++; if (busy16 !== 1'b1) $display("FAIL t4_accept_busy: got %b want 1", busy16); else pass_cnt++;
      chk_cnt++; if (cnt16 !== 16'd32) $display("FAIL t4_cnt_kept: got %0d want 32", cnt16); else pass_cnt++;
   endtask

   // T5: en drops at gate=30; no result, old cnt kept; a fresh window then takes 65 clk.
   task automatic test_abort;
      div_half = 4;
      tick(30);
      chk_cnt++; if (busy16 !== 1'b1) $display("FAIL t5_busy_gate30: got %b want 1", busy16); else pass_cnt++;
      en = 1'b0;
      tick(1);
      chk_cnt++; if (busy16 !== 1'b0) $display("FAIL t5_abort_busy: got %b want 0", busy16); else pass_cnt++;
      chk_cnt++; if (valid16 !== 1'b0) $display("FAIL t5_abort_valid: got %b want 0", valid16); else pass_cnt++;
      tick(10);
      chk_cnt++; if (valid16 !== 1'b0 || cnt16 !== 16'd32)
         $display("FAIL t5_idle: got v=%b cnt=%0d want v=0 cnt=32", valid16, cnt16);
      else pass_cnt++;
      en = 1'b1;
      tick(64);
      chk_cnt++; if (valid16 !== 1'b0 || busy16 !== 1'b1)
         $display("FAIL t5_fresh_early: got v=%b b=%b want v=0 b=1", valid16, busy16);
      else pass_cnt++;
      tick(1);
      chk_cnt++; if (valid16 !== 1'b1) $display("FAIL t5_fresh_valid: got %b want 1", valid16); else pass_cnt++;
      chk_cnt++; if (cnt16 !== 16'd8) $display("FAIL t5_fresh_cnt: got %0d want 8", cnt16); else pass_cnt++;
   endtask

   // T6: asynchronous reset in HOLD clears the held result without a clock edge.
   task automatic test_reset_in_hold;
      tick(2);
      chk_cnt++; if (valid16 !== 1'b1 || cnt16 !== 16'd8)
         $display("FAIL t6_pre: got v=%b cnt=%0d want v=1 cnt=8", valid16, cnt16);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++; if ({cnt16, valid16, ovf16, busy16} !== 19'd0)
         $display("FAIL t6_async16: got cnt=%0d v=%b o=%b b=%b want all 0", cnt16, valid16, ovf16, busy16);
      else pass_cnt++;
      chk_cnt++; if ({cnt4, valid4, ovf4, busy4} !== 7'd0)
         $display("FAIL t6_async4: got cnt=%0d v=%b o=%b b=%b want all 0", cnt4, valid4, ovf4, busy4);
      else pass_cnt++;
      #1;
      rst = 1'b0;
      en = 1'b0;
      tick(3);
      chk_cnt++; if (valid16 !== 1'b0 || busy16 !== 1'b0)
         $display("FAIL t6_idle: got v=%b b=%b want 0 0", valid16, busy16);
      else pass_cnt++;
      en = 1'b1;
      tick(1);
      chk_cnt++; if (busy16 !== 1'b1) $display("FAIL t6_restart: got %b want 1", busy16); else pass_cnt++;
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_back_to_back();
      test_saturation();
      test_backpressure();
      test_abort();
      test_reset_in_hold();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
